// File: rtl/mem_pkg.sv
// Shared constants and entry type for the posted-write buffer between the core and exmemory.
package mem_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int PTR_W     = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] adr;
    logic [DEF_WIDTH-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular {adr,data} store for the write buffer: pointers, occupancy, per-entry valid bits.
// Every entry is exposed so the top level can run an address compare across the whole queue.
module wbuf_fifo
  import mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic [WIDTH-1:0]                push_adr,
  input  logic [WIDTH-1:0]                push_data,
  output logic [WIDTH-1:0]                head_adr,
  output logic [WIDTH-1:0]                head_data,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH)-1:0]        tail,
  output logic [DEPTH-1:0]                valid,
  output logic [DEPTH-1:0][WIDTH-1:0]     entry_adr,
  output logic [DEPTH-1:0][WIDTH-1:0]     entry_data
);

  localparam int P_W = $clog2(DEPTH);
  localparam int C_W = P_W + 1;

  logic [P_W-1:0]   head_reg, tail_reg;
  logic [C_W-1:0]   count_reg;
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [WIDTH-1:0] adr_mem  [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_reg == C_W'(DEPTH));
  assign empty   = (count_reg == '0);
  // Guard here as well so a misbehaving caller can never over- or under-run the queue.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    valid_next = valid_reg;
    if (do_pop)
      valid_next[head_reg] = 1'b0;
    if (do_push)
      valid_next[tail_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (do_push)
        tail_reg <= tail_reg + P_W'(1);
      if (do_pop)
        head_reg <= head_reg + P_W'(1);
      count_reg <= count_reg + C_W'(do_push) - C_W'(do_pop);
      valid_reg <= valid_next;
    end
  end

  // Payload needs no reset: valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      adr_mem[tail_reg]  <= push_adr;
      data_mem[tail_reg] <= push_data;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_adr[gi]  = adr_mem[gi];
      assign entry_data[gi] = data_mem[gi];
    end
  endgenerate

  assign head_adr  = adr_mem[head_reg];
  assign head_data = data_mem[head_reg];
  assign count     = count_reg;
  assign tail      = tail_reg;
  assign valid     = valid_reg;

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer: queues core stores and retires them on free memory cycles.
// Define WBUF_FORWARD_EN to serve reads from the youngest matching queued write instead of stalling.
module mem_write_buffer
  import mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memread,
  input  logic                   memwrite,
  input  logic [WIDTH-1:0]       adr,
  input  logic [WIDTH-1:0]       writedata,
  output logic [WIDTH-1:0]       memdata,
  output logic                   stall,
  output logic                   mem_we,
  output logic [WIDTH-1:0]       mem_adr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic [WIDTH-1:0]       mem_rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int P_W = $clog2(DEPTH);

  logic                        full, empty;
  logic                        push, drain;
  logic                        rd_req, illegal, full_write, port_idle;
  logic [WIDTH-1:0]            head_adr, head_data;
  logic [P_W-1:0]              tail_ptr;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][WIDTH-1:0] entry_adr, entry_data;

  wbuf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (drain),
    .push_adr   (adr),
    .push_data  (writedata),
    .head_adr   (head_adr),
    .head_data  (head_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .tail       (tail_ptr),
    .valid      (valid),
    .entry_adr  (entry_adr),
    .entry_data (entry_data)
  );

  assign rd_req     = memread && !memwrite;
  assign illegal    = memread && memwrite;
  assign full_write = memwrite && full;
  assign push       = memwrite && !full;

`ifdef WBUF_FORWARD_EN
  logic [DEPTH-1:0]            hit_vec;
  logic [DEPTH-1:0][WIDTH-1:0] hit_data;
  logic                        fwd_hit;
  logic [WIDTH-1:0]            fwd_data;

  // Offset gi looks at the entry written gi+1 pushes ago, so lower offsets are younger.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
      logic [P_W-1:0] idx;
      assign idx          = tail_ptr - P_W'(gi + 1);
      assign hit_vec[gi]  = valid[idx] && (entry_adr[idx] == adr);
      assign hit_data[gi] = entry_data[idx];
    end
  endgenerate

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = hit_data[i];
      end
    end
  end

  assign port_idle = !memread && !memwrite;
  assign stall     = full_write || illegal;
  assign memdata   = (rd_req && fwd_hit) ? fwd_data : mem_rdata;
`else
  logic unused_fwd;
  assign unused_fwd = ^{tail_ptr, valid, entry_adr, entry_data};

  // A read behind queued writes yields the port to the drain until the queue is empty.
  assign port_idle = (!memread && !memwrite) || rd_req;
  assign stall     = full_write || illegal || (rd_req && !empty);
  assign memdata   = mem_rdata;
`endif

  assign drain     = !empty && (port_idle || full_write);
  assign mem_we    = drain;
  assign mem_adr   = drain ? head_adr : adr;
  assign mem_wdata = head_data;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer: queue-level reference model plus directed literal checks.
module tb_mem_write_buffer;
  import mem_pkg::*;

  localparam int D = 4;
`ifdef WBUF_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, memread, memwrite;
  logic [7:0] adr, writedata, memdata, mem_adr, mem_wdata, mem_rdata;
  logic       stall, mem_we;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_write_buffer #(.WIDTH(8), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .memdata   (memdata),
    .stall     (stall),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .count     (count)
  );

  // Environment memory and the reference memory seeded from the same random image
  logic [7:0]  exmem     [256];
  logic [7:0]  model_mem [256];
  bit          seeded    = 0;
  bit          load_done = 0;
  wbuf_entry_t q[$];

  assign mem_rdata = exmem[mem_adr];

  always @(posedge clk) begin
    if (!load_done && seeded) begin
      for (int i = 0; i < 256; i++) exmem[i] <= model_mem[i];
      load_done <= 1'b1;
    end else if (mem_we) begin
      exmem[mem_adr] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of posted writes, advanced once per cycle.
  always @(negedge clk) begin
    bit         e_full, e_rd, e_drain, e_stall, hit;
    int         sz;
    logic [7:0] e_data;
    if (!reset) begin
      if (!seeded) begin
        for (int i = 0; i < 256; i++) model_mem[i] = 8'($urandom);
        model_mem[11] = 8'h5A;
        seeded = 1;
      end
      q.delete();
      chk("m_rst_count", int'(count), 0);
      chk("m_rst_we", int'(mem_we), 0);
      chk("m_rst_stall", int'(stall), 0);
    end else begin
      sz      = q.size();
      e_full  = (sz == D);
      e_rd    = memread && !memwrite;
      e_drain = (sz > 0) && ((!memread && !memwrite) || (memwrite && e_full) || (!FWD && e_rd));
      e_stall = (memwrite && e_full) || (memread && memwrite) || (!FWD && e_rd && sz > 0);
      chk("m_count", int'(count), sz);
      chk("m_stall", int'(stall), int'(e_stall));
      chk("m_we", int'(mem_we), int'(e_drain));
      if (e_drain) begin
        chk("m_mem_adr", int'(mem_adr), int'(q[0].adr));
        chk("m_mem_wdata", int'(mem_wdata), int'(q[0].data));
      end else if (memread) begin
        chk("m_rd_adr", int'(mem_adr), int'(adr));
      end
      if (e_rd && !e_stall) begin
        hit    = 0;
        e_data = model_mem[adr];
        if (FWD) begin
          for (int k = sz - 1; k >= 0; k--) begin
            if (!hit && q[k].adr == adr) begin
              e_data = q[k].data;
              hit    = 1;
            end
          end
        end
        chk("m_memdata", int'(memdata), int'(e_data));
        $display("read  adr=%0d data=%0d", adr, memdata);
      end
      if (e_drain) begin
        $display("retire adr=%0d data=%0d", q[0].adr, q[0].data);
        model_mem[q[0].adr] = q[0].data;
        void'(q.pop_front());
      end
      if (memwrite && !e_full) q.push_back('{adr: adr, data: writedata});
    end
  end

  task automatic drive(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    memread   = r;
    memwrite  = w;
    adr       = a;
    writedata = d;
  endtask

  task automatic wait_empty(input string nm);
    bit done = 0;
    drive(0, 0, 8'd0, 8'd0);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (count == 0) done = 1;
      else @(posedge clk);
    end
    chk(nm, int'(done), 1);
  endtask

  initial begin
    bit         hold = 0;
    bit         done;
    int         stalls;
    int         r;
    reset = 0; memread = 0; memwrite = 0; adr = '0; writedata = '0;
    repeat (2) @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_we", int'(mem_we), 0);
    chk("reset_stall", int'(stall), 0);
    @(posedge clk); #1 reset = 1;

    // Basic post of 255 <- 210
    drive(0, 1, 8'd255, 8'd210);
    @(negedge clk);
    chk("post_cnt0", int'(count), 0);
    drive(0, 0, 8'd0, 8'd0);
    @(negedge clk);
    chk("post_cnt1", int'(count), 1);
    chk("post_we", int'(mem_we), 1);
    chk("post_adr", int'(mem_adr), 255);
    chk("post_wdata", int'(mem_wdata), 210);
    @(negedge clk);
    chk("post_cnt2", int'(count), 0);
    chk("post_mem", int'(exmem[255]), 210);

    // Five back-to-back writes into a four-entry buffer
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'(40 + i), 8'(8'hA0 + i));
      @(negedge clk);
      if (i < 4) begin
        chk("full_nostall", int'(stall), 0);
        chk("full_fill", int'(count), i);
      end else begin
        chk("full_stall", int'(stall), 1);
        chk("full_at4", int'(count), 4);
        @(negedge clk);
        chk("full_retry_stall", int'(stall), 0);
        chk("full_retry_cnt", int'(count), 3);
      end
    end
    wait_empty("full_drain");
    chk("full_mem44", int'(exmem[44]), 8'hA4);

    // Two writes to the same address then a read of it
    drive(0, 1, 8'd10, 8'h11);
    drive(0, 1, 8'd10, 8'h22);
    drive(1, 0, 8'd10, 8'd0);
    if (FWD) begin
      @(negedge clk);
      chk("fwd_data", int'(memdata), 8'h22);
      chk("fwd_stall", int'(stall), 0);
      drive(1, 0, 8'd11, 8'd0);
      @(negedge clk);
      chk("fwd_miss", int'(memdata), 8'h5A);
    end else begin
      stalls = 0;
      done   = 0;
      for (int i = 0; i < 10 && !done; i++) begin
        @(negedge clk);
        if (!stall) done = 1;
        else stalls++;
      end
      chk("nofwd_done", int'(done), 1);
      chk("nofwd_stalls", stalls, 2);
      chk("nofwd_data", int'(memdata), 8'h22);
    end
    wait_empty("rd_drain");

    // Reset with three writes queued
    drive(0, 1, 8'd60, 8'h61);
    drive(0, 1, 8'd61, 8'h62);
    drive(0, 1, 8'd62, 8'h63);
    @(negedge clk);
    chk("midrst_pre", int'(count), 2);
    @(posedge clk);
    #1;
    reset = 0; memwrite = 0; memread = 0;
    chk("midrst_we_async", int'(mem_we), 0);
    @(negedge clk);
    chk("midrst_count", int'(count), 0);
    @(posedge clk); #1 reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_nowe", int'(mem_we), 0);
    end
    for (int a = 60; a < 63; a++) chk("midrst_mem", int'(exmem[a]), int'(model_mem[a]));

    // Randomised traffic over a small address window so forwarding hits occur
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (!reset) begin
        reset = 1;
        hold  = 0;
      end
      if (!hold) begin
        r = $urandom_range(0, 99);
        memread = 0; memwrite = 0;
        adr = 8'($urandom_range(0, 15));
        writedata = 8'($urandom);
        if (r < 2) reset = 0;
        else if (r < 45) memwrite = 1;
        else if (r < 80) memread = 1;
        else if (r < 84) begin memread = 1; memwrite = 1; end
      end
      @(negedge clk);
      hold = reset && stall && !(memread && memwrite);
    end
    wait_empty("final_drain");
    for (int a = 0; a < 256; a++) chk("final_mem", int'(exmem[a]), int'(model_mem[a]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
